// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle HI/LO engine for MULT/MULTU/DIV/DIVU.
// It uses shift-add multiply and restoring divide, one bit per cycle.
// It ends with a single 64-bit HI:LO commit and holds the PC while busy.
// Optional feature macro: MULDIV_ACCUM_EN. When defined, it enables MADD/MADDU/MSUB/MSUBU (Op 4-7).
module muldiv_sequencer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Start,
    input  logic [2:0]                Op,
    input  logic [DATA_WIDTH-1:0]     A,
    input  logic [DATA_WIDTH-1:0]     B,
    input  logic [2*DATA_WIDTH-1:0]   HiLoRead,
    output logic                      Busy,
    output logic                      Stall,
    output logic                      HiLoEn,
    output logic [2*DATA_WIDTH-1:0]   HiLoWrite,
    output logic                      DivZero
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned W2    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic            busy_q, busy_d;
    logic            hilo_en_q, hilo_en_d;
    logic            div_zero_q, div_zero_d;
    logic [W2-1:0]   hilo_write_q;

    logic            accept;
    logic            op_valid;

    // Iteration registers.
    // Multiply: {p_hi, p_lo} is the running product, and p_lo starts as the multiplier.
    // Divide: p_hi is the partial remainder, and p_lo shifts the dividend out and the quotient in.
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     p_hi_q;
    logic [W-1:0]     p_lo_q;
    logic [W-1:0]     opnd_q;
    logic             is_div_q;
    logic             dz_q;
    logic             neg_res_q;
    logic             neg_rem_q;

`ifdef MULDIV_ACCUM_EN
    logic             is_acc_q;
    logic             is_sub_q;
    logic [W2-1:0]    acc_q;
`else
    logic             unused_hilo;
    assign unused_hilo = ^HiLoRead;
`endif

    // Decode of the instruction presented at the accept edge.
    logic          cap_signed;
    logic          cap_a_neg;
    logic          cap_b_neg;
    logic          cap_div;
    logic          cap_dz;
    logic [W-1:0]  cap_a_mag;
    logic [W-1:0]  cap_b_mag;

    // One-bit step of the multiply and divide engines.
    logic [W:0]    addend;
    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic [W:0]    div_diff;
    logic          div_ge;
    logic [W-1:0]  step_hi;
    logic [W-1:0]  step_lo;

    // Sign correction and accumulation applied in FIXUP.
    logic [W2-1:0] mag;
    logic [W2-1:0] prod_s;
    logic [W-1:0]  quo;
    logic [W-1:0]  rem;
    logic [W2-1:0] fix_res;

    // Op legality: accumulate ops exist only when the feature is built in.
    always_comb begin
`ifdef MULDIV_ACCUM_EN
        op_valid = 1'b1;
`else
        op_valid = ~Op[2];
`endif
    end

    // Next-state and output logic.
    // Stall must rise in the accept cycle itself, so it is combinational.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        Stall   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start && op_valid) begin
                    accept  = 1'b1;
                    Stall   = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                Stall = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                Stall   = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d     = (state_d != S_IDLE);
        hilo_en_d  = (state_d == S_WRITE);
        div_zero_d = (state_d == S_WRITE) && dz_q;
    end

    // State register and registered handshake outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            hilo_en_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            hilo_en_q  <= hilo_en_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Operand decode: signed ops have even Op codes; DIV and DIVU are 2 and 3.
    always_comb begin
        cap_signed = ~Op[0];
        cap_a_neg  = cap_signed & A[W-1];
        cap_b_neg  = cap_signed & B[W-1];
        cap_a_mag  = cap_a_neg ? -A : A;
        cap_b_mag  = cap_b_neg ? -B : B;
        cap_div    = (Op[2:1] == 2'b01);
        cap_dz     = cap_div && (B == '0);
    end

    // One iteration: a conditional add then shift right, or a restoring subtract then shift left.
    always_comb begin
        addend    = p_lo_q[0] ? {1'b0, opnd_q} : '0;
        mul_sum   = {1'b0, p_hi_q} + addend;
        div_shift = {p_hi_q, p_lo_q[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[W];
        if (is_div_q) begin
            step_hi = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
            step_lo = {p_lo_q[W-2:0], div_ge};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], p_lo_q[W-1:1]};
        end
    end

    // Final result: restore signs, apply the divide-by-zero pattern, and optionally accumulate.
    always_comb begin
        mag    = {p_hi_q, p_lo_q};
        prod_s = neg_res_q ? -mag : mag;
        quo    = neg_res_q ? -p_lo_q : p_lo_q;
        rem    = neg_rem_q ? -p_hi_q : p_hi_q;
        if (is_div_q) begin
            if (dz_q) begin
                fix_res = {p_lo_q, {W{1'b1}}};
            end else begin
                fix_res = {rem, quo};
            end
        end else begin
            fix_res = prod_s;
`ifdef MULDIV_ACCUM_EN
            if (is_acc_q) begin
                fix_res = is_sub_q ? (acc_q - prod_s) : (acc_q + prod_s);
            end
`endif
        end
    end

    // Datapath registers: capture on accept, iterate in CALC, commit the result in FIXUP.
    // For a zero divisor, the raw dividend is parked in p_lo and iteration is frozen.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q        <= '0;
            p_hi_q       <= '0;
            p_lo_q       <= '0;
            opnd_q       <= '0;
            is_div_q     <= 1'b0;
            dz_q         <= 1'b0;
            neg_res_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            hilo_write_q <= '0;
`ifdef MULDIV_ACCUM_EN
            is_acc_q     <= 1'b0;
            is_sub_q     <= 1'b0;
            acc_q        <= '0;
`endif
        end else begin
            if (accept) begin
                cnt_q     <= '0;
                p_hi_q    <= '0;
                p_lo_q    <= cap_div ? (cap_dz ? A : cap_a_mag) : cap_b_mag;
                opnd_q    <= cap_div ? cap_b_mag : cap_a_mag;
                is_div_q  <= cap_div;
                dz_q      <= cap_dz;
                neg_res_q <= cap_a_neg ^ cap_b_neg;
                neg_rem_q <= cap_a_neg;
`ifdef MULDIV_ACCUM_EN
                is_acc_q  <= Op[2];
                is_sub_q  <= Op[2] & Op[1];
                acc_q     <= HiLoRead;
`endif
            end else if (state_q == S_CALC) begin
                cnt_q <= cnt_q + 1'b1;
                if (!dz_q) begin
                    p_hi_q <= step_hi;
                    p_lo_q <= step_lo;
                end
            end
            if (state_q == S_FIXUP) begin
                hilo_write_q <= fix_res;
            end
        end
    end

    assign Busy      = busy_q;
    assign HiLoEn    = hilo_en_q;
    assign HiLoWrite = hilo_write_q;
    assign DivZero   = div_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer.
// It runs directed and random operations against an arithmetic reference model.
// Accumulate checks depend on MULDIV_ACCUM_EN.
module tb_muldiv_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [63:0] HiLoRead;
    logic        Busy;
    logic        Stall;
    logic        HiLoEn;
    logic [63:0] HiLoWrite;
    logic        DivZero;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .HiLoRead  (HiLoRead),
        .Busy      (Busy),
        .Stall     (Stall),
        .HiLoEn    (HiLoEn),
        .HiLoWrite (HiLoWrite),
        .DivZero   (DivZero)
    );

    always #5 Clk = ~Clk;

    // Single comparison point.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model from plain integer arithmetic. Bit 64 is the expected DivZero.
    function automatic logic [64:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hl);
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'h0, a} * {32'h0, b};
        case (op)
            3'd0: return {1'b0, 64'(sp)};
            3'd1: return {1'b0, up};
            3'd2: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {1'b0, 32'(r), 32'(q)};
            end
            3'd3: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            3'd4: return {1'b0, hl + 64'(sp)};
            3'd5: return {1'b0, hl + up};
            3'd6: return {1'b0, hl - 64'(sp)};
            default: return {1'b0, hl - up};
        endcase
    endfunction

    // Present one instruction and hold Start through WRITE.
    // After acceptance, the operand inputs are scrambled.
    // Observes exactly 35 cycles, then returns at the next negedge with Start still high.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] hl,
                          input logic [63:0] exp, input logic exp_dz);
        int          stall_n = 0;
        int          busy_n  = 0;
        int          en_n    = 0;
        int          en_cyc  = -1;
        logic [63:0] res     = '0;
        logic        dz      = 1'b0;
        Start    = 1'b1;
        Op       = op;
        A        = a;
        B        = b;
        HiLoRead = hl;
        for (int cyc = 0; cyc < 35; cyc++) begin
            #1;
            if (Stall)  stall_n++;
            if (Busy)   busy_n++;
            if (HiLoEn) begin
                en_n++;
                en_cyc = cyc;
                res    = HiLoWrite;
                dz     = DivZero;
            end
            @(negedge Clk);
            if (cyc == 0) begin
                Op       = 3'($urandom);
                A        = $urandom;
                B        = $urandom;
                HiLoRead = {$urandom, $urandom};
            end
        end
        check({tag, " stall_cycles"}, 64'(stall_n), 64'd34);
        check({tag, " busy_cycles"},  64'(busy_n),  64'd34);
        check({tag, " hiloen_count"}, 64'(en_n),    64'd1);
        check({tag, " hiloen_cycle"}, 64'(en_cyc),  64'd34);
        check({tag, " result"},       res,          exp);
        check({tag, " divzero"},      64'(dz),      64'(exp_dz));
    endtask

    // Idle observation: nothing may stall, run, or commit.
    task automatic watch_idle(input string tag, input int cycles);
        int act = 0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            if (Stall || Busy || HiLoEn || DivZero) act++;
            @(negedge Clk);
        end
        check({tag, " idle_activity"}, 64'(act), 64'd0);
    endtask

    initial begin
        logic [64:0] m;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] rhl;
        int          sel;

        Rst = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0; HiLoRead = '0;
        repeat (2) @(negedge Clk);
        #1;
        check("reset busy",      64'(Busy),    64'd0);
        check("reset stall",     64'(Stall),   64'd0);
        check("reset hiloen",    64'(HiLoEn),  64'd0);
        check("reset hilowrite", HiLoWrite,    64'd0);
        check("reset divzero",   64'(DivZero), 64'd0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        // These directed cases use the documented example values. Start stays high, so they also run back to back.
        run_op("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 64'h0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op("divu_100_7",  3'd3, 32'd100, 32'd7, 64'h0, {32'd2, 32'd14}, 1'b0);
        run_op("div_m7_2",    3'd2, 32'hFFFF_FFF9, 32'd2, 64'h0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_op("div_5_0",     3'd2, 32'd5, 32'd0, 64'h0, {32'd5, 32'hFFFF_FFFF}, 1'b1);
        run_op("div_min_m1",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, {32'h0, 32'h8000_0000}, 1'b0);
        run_op("multu_b2b_1", 3'd1, 32'd6, 32'd9, 64'h0, 64'd54, 1'b0);
        run_op("multu_b2b_2", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'hFFFF_FFFE_0000_0001, 1'b0);
        Start = 1'b0;
        watch_idle("after_b2b", 4);

        // Abort in the middle of CALC while the counter is at 10.
        Start = 1'b1; Op = 3'd1; A = 32'd1234; B = 32'd5678;
        repeat (11) @(negedge Clk);
        #1;
        check("pre_abort busy", 64'(Busy), 64'd1);
        Rst   = 1'b1;
        Start = 1'b0;
        #1;
        check("abort busy",  64'(Busy),  64'd0);
        check("abort stall", 64'(Stall), 64'd0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        watch_idle("post_abort", 40);
        check("post_abort hilowrite", HiLoWrite, 64'd0);
        run_op("multu_3x4", 3'd1, 32'd3, 32'd4, 64'h0, 64'd12, 1'b0);

`ifdef MULDIV_ACCUM_EN
        run_op("madd", 3'd4, 32'd2, 32'd3, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0006, 1'b0);
        run_op("msubu", 3'd7, 32'd2, 32'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
`else
        Start = 1'b0;
        @(negedge Clk);
        Start = 1'b1; Op = 3'd4; A = 32'd2; B = 32'd3; HiLoRead = 64'h0000_0001_0000_0000;
        watch_idle("madd_disabled", 40);
        Op = 3'($urandom_range(4, 7));
        watch_idle("accum_disabled", 10);
`endif

        // Randomized operations checked against the reference model.
        for (int i = 0; i < 32; i++) begin
`ifdef MULDIV_ACCUM_EN
            rop = 3'($urandom_range(0, 7));
`else
            rop = 3'($urandom_range(0, 3));
`endif
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = $urandom;
            rhl = {$urandom, $urandom};
            if (sel == 0) rb = 32'h0;
            if (sel == 1) begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
            if (sel == 2) rb = 32'hFFFF_FFFF;
            if (sel == 3) ra = 32'h8000_0000;
            m = ref_model(rop, ra, rb, rhl);
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, rhl, m[63:0], m[64]);
        end
        Start = 1'b0;
        watch_idle("final", 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so that the run always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
